// File: rtl/param_elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline slice.
package param_elastic_pipe_pkg;

  // Width of the occupancy counter; at least 1 bit so the DEPTH=0 bypass keeps a legal port.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_elastic_pipe_if.sv
// Upstream/downstream handshake bundle plus occupancy for param_elastic_pipe.
interface param_elastic_pipe_if
  import param_elastic_pipe_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/param_elastic_pipe_pipe_stage.sv
// One data+valid register of the elastic pipe; flush beats advance.
module pipe_stage #(
  parameter int WIDTH      = 18,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  input  logic             adv,
  input  logic             flush,
  output logic [WIDTH-1:0] data_q,
  output logic             vld_q
);
  logic [WIDTH-1:0] data_d;
  logic             vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      vld_d = 1'b0;
      if (CLEAR_DATA) data_d = '0;
    end else if (adv) begin
      vld_d = up_valid;
      // bubbles leave the data register untouched
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: rtl/param_elastic_pipe.sv
// DEPTH-stage valid/ready pipe with bubble collapse, clock enable, flush and occupancy count.
module param_elastic_pipe
  import param_elastic_pipe_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 2,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_enable,
  input  logic                flush,
  param_elastic_pipe_if.slave io
);
  localparam int CW = cnt_w(DEPTH);

  logic open_g;
  assign open_g = clk_enable & ~flush;

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = &{1'b0, clk, rst_n};
      assign io.out_data   = io.in_data;
      assign io.out_valid  = io.in_valid & open_g;
      assign io.in_ready   = io.out_ready & open_g;
      assign io.count      = '0;
    end else begin : g_pipe
      logic [DEPTH:0]            rdy;
      logic [DEPTH:0]            vchain;
      logic [DEPTH:0][WIDTH-1:0] dchain;
      logic [DEPTH-1:0]          adv;
      logic                      run_q, run_d;
      logic [CW-1:0]             cnt_q, cnt_d;
      logic                      in_xfer, out_xfer;

      assign dchain[0]  = io.in_data;
      assign vchain[0]  = io.in_valid;
      assign rdy[DEPTH] = io.out_ready;

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        assign rdy[k] = ~vchain[k+1] | rdy[k+1];
        assign adv[k] = rdy[k] & open_g & run_q;
        pipe_stage #(.WIDTH(WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_stage (
          .clk      (clk),
          .rst_n    (rst_n),
          .up_data  (dchain[k]),
          .up_valid (vchain[k]),
          .adv      (adv[k]),
          .flush    (flush),
          .data_q   (dchain[k+1]),
          .vld_q    (vchain[k+1])
        );
      end

      // run_q holds the input side closed until the first edge after reset release
      assign io.in_ready  = rdy[0] & open_g & run_q;
      assign io.out_valid = vchain[DEPTH] & open_g;
      assign io.out_data  = dchain[DEPTH];
      assign io.count     = cnt_q;

      assign in_xfer  = io.in_valid & io.in_ready;
      assign out_xfer = io.out_valid & io.out_ready;

      always_comb begin
        run_d = 1'b1;
        cnt_d = cnt_q;
        if (flush)                    cnt_d = '0;
        else if (in_xfer & ~out_xfer) cnt_d = cnt_q + CW'(1);
        else if (~in_xfer & out_xfer) cnt_d = cnt_q - CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          run_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          run_q <= run_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_param_elastic_pipe.sv
// Self-checking bench: DEPTH=2 (CLEAR_DATA=1), DEPTH=3 (CLEAR_DATA=0) and DEPTH=0 pipes on shared stimulus.
module tb_param_elastic_pipe;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clk_enable = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  param_elastic_pipe_if #(.WIDTH(W), .DEPTH(2)) ifa();
  param_elastic_pipe_if #(.WIDTH(W), .DEPTH(3)) ifb();
  param_elastic_pipe_if #(.WIDTH(W), .DEPTH(0)) ifz();

  assign ifa.in_data = in_data;  assign ifa.in_valid = in_valid;  assign ifa.out_ready = out_ready;
  assign ifb.in_data = in_data;  assign ifb.in_valid = in_valid;  assign ifb.out_ready = out_ready;
  assign ifz.in_data = in_data;  assign ifz.in_valid = in_valid;  assign ifz.out_ready = out_ready;

  param_elastic_pipe #(.WIDTH(W), .DEPTH(2), .CLEAR_DATA(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .flush(flush), .io(ifa.slave));
  param_elastic_pipe #(.WIDTH(W), .DEPTH(3), .CLEAR_DATA(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .flush(flush), .io(ifb.slave));
  param_elastic_pipe #(.WIDTH(W), .DEPTH(0), .CLEAR_DATA(1'b0)) u_z (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .flush(flush), .io(ifz.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: words as cars on a DEPTH-slot road ----------------
  typedef struct {
    logic [W-1:0] d;
    int           p;   // slot index, 0 = input side, D-1 = output side
  } ent_t;

  ent_t         mq[2][$];   // oldest first
  logic [W-1:0] mlast[2];   // last word that rolled into the output slot
  bit           running = 1'b0;

  function automatic int md(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic bit mclr(input int m);
    return (m == 0);
  endfunction

  // After everyone rolls forward as far as they can, the lowest slot still blocked
  function automatic int free_limit(input int m, input bit ordy);
    int lim = md(m);
    for (int i = 0; i < mq[m].size(); i++) begin
      int p = mq[m][i].p;
      if (i == 0 && p == md(m) - 1) begin
        if (!ordy) lim = p;
      end else begin
        if (p + 1 < lim) p = p + 1;
        lim = p;
      end
    end
    return lim;
  endfunction

  task automatic model_step(input int m);
    ent_t nq[$];
    int   lim = md(m);
    for (int i = 0; i < mq[m].size(); i++) begin
      ent_t e = mq[m][i];
      if (i == 0 && e.p == md(m) - 1) begin
        if (!out_ready) begin
          nq.push_back(e);
          lim = e.p;
        end
      end else begin
        int np = (e.p + 1 < lim) ? e.p + 1 : e.p;
        if (np == md(m) - 1 && e.p != md(m) - 1) mlast[m] = e.d;
        e.p = np;
        nq.push_back(e);
        lim = np;
      end
    end
    if (in_valid && lim > 0) begin
      ent_t n;
      n.d = in_data;
      n.p = 0;
      nq.push_back(n);
    end
    mq[m] = nq;
  endtask

  initial begin
    mlast[0] = '0;
    mlast[1] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        mlast[m] = '0;
      end
      running = 1'b0;
    end else begin
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (flush) begin
          mq[m].delete();
          if (mclr(m)) mlast[m] = '0;
        end else if (clk_enable && running) begin
          model_step(m);
        end
      end
      running = 1'b1;
    end
  end

  task automatic cmp_model(input int m, input string tag, input logic ir, input logic ov,
                           input logic [W-1:0] od, input logic [1:0] cnt);
    int lim = free_limit(m, out_ready);
    bit eir = running && clk_enable && !flush && (lim > 0);
    bit eov = clk_enable && !flush && (mq[m].size() > 0) && (mq[m][0].p == md(m) - 1);
    chk({tag, "_in_ready"},  32'(ir),  32'(eir));
    chk({tag, "_out_valid"}, 32'(ov),  32'(eov));
    chk({tag, "_out_data"},  32'(od),  32'(mlast[m]));
    chk({tag, "_count"},     32'(cnt), 32'(mq[m].size()));
  endtask

  // ---------------- per-cycle compare + DUT A transfer monitor ----------------
  logic [W-1:0] a_out[$];
  int           a_ostamp[$];
  int           a_istamp[$];

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_model(0, "a", ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.count);
      cmp_model(1, "b", ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.count);
      chk("z_out_data",  32'(ifz.out_data),  32'(in_data));
      chk("z_out_valid", 32'(ifz.out_valid), 32'(in_valid & clk_enable & ~flush));
      chk("z_in_ready",  32'(ifz.in_ready),  32'(out_ready & clk_enable & ~flush));
      chk("z_count",     32'(ifz.count),     32'd0);
      if (ifa.out_valid && out_ready) begin
        a_out.push_back(ifa.out_data);
        a_ostamp.push_back(cyc);
      end
      if (in_valid && ifa.in_ready) a_istamp.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic clear_mon();
    a_out.delete();
    a_ostamp.delete();
    a_istamp.delete();
  endtask

  initial begin
    int nb;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_count",     32'(ifa.count),     32'd0);
    chk("rst_in_ready",  32'(ifa.in_ready),  32'd0);
    chk("rst_out_data",  32'(ifa.out_data),  32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // streaming, no backpressure
    clear_mon();
    out_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      if (w == 5) chk("stream_count", 32'(ifa.count), 32'd2);
      push_a(W'(w));
    end
    repeat (5) tick();
    chk("stream_n", a_out.size(), 32'd8);
    if (a_out.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("stream_word", 32'(a_out[i]), 32'(i + 1));
      chk("stream_latency", a_ostamp[0] - a_istamp[0], 32'd2);
      chk("stream_rate",    a_ostamp[7] - a_ostamp[0], 32'd7);
    end

    // backpressure, then full-and-pop
    clear_mon();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nb = 0;
    in_data = W'(18'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) chk("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
      if (ifa.in_ready) nb++;
      tick();
      in_data = W'(18'h100 + nb);
    end
    chk("bp_count",    32'(ifa.count), 32'd2);
    chk("bp_accepted", nb,             32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fp_in_ready",  32'(ifa.in_ready),  32'd1);
    chk("fp_count",     32'(ifa.count),     32'd2);
    chk("fp_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("fp_out_data",  32'(ifa.out_data),  32'h100);
    nb++;
    tick();
    in_data = W'(18'h100 + nb);
    @(negedge clk);
    chk("fp_count_hold", 32'(ifa.count), 32'd2);
    if (ifa.in_ready) nb++;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_n", a_out.size(), nb);
    for (int i = 0; i < a_out.size(); i++) chk("bp_word", 32'(a_out[i]), 32'(18'h100 + i));

    // clock enable freeze
    out_ready = 1'b0;
    push_a(W'(18'h200));
    push_a(W'(18'h201));
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = W'(18'h202);
    clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ce_in_ready",  32'(ifa.in_ready),  32'd0);
      chk("ce_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("ce_count",     32'(ifa.count),     32'd2);
      chk("ce_out_data",  32'(ifa.out_data),  32'h200);
      tick();
    end
    clk_enable = 1'b1;
    @(negedge clk);
    chk("ce_resume_valid", 32'(ifa.out_valid), 32'd1);
    chk("ce_resume_data",  32'(ifa.out_data),  32'h200);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // flush with a full pipe
    out_ready = 1'b0;
    push_a(W'(18'h300));
    push_a(W'(18'h301));
    chk("fl_pre_count", 32'(ifa.count), 32'd2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(18'h3AB);
    flush     = 1'b1;
    @(negedge clk);
    chk("fl_out_valid",   32'(ifa.out_valid), 32'd0);
    chk("fl_in_ready",    32'(ifa.in_ready),  32'd0);
    chk("fl_z_out_valid", 32'(ifz.out_valid), 32'd0);
    chk("fl_z_in_ready",  32'(ifz.in_ready),  32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_count",       32'(ifa.count),     32'd0);
    chk("fl_post_valid",  32'(ifa.out_valid), 32'd0);
    chk("fl_post_data",   32'(ifa.out_data),  32'd0);
    chk("fl_z_follow",    32'(ifz.out_data),  32'h3AB);
    chk("fl_z_valid",     32'(ifz.out_valid), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // reset with two words in flight
    out_ready = 1'b1;
    push_a(W'(18'h400));
    push_a(W'(18'h401));
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rmid_count",     32'(ifa.count),     32'd0);
    chk("rmid_in_ready",  32'(ifa.in_ready),  32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    clear_mon();
    push_a(W'(18'h4AB));
    repeat (4) tick();
    chk("rmid_new_n", a_out.size(), 32'd1);
    if (a_out.size() > 0) chk("rmid_new_word", 32'(a_out[0]), 32'h4AB);

    // randomized traffic, checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_data    = W'($urandom);
      out_ready  = ($urandom_range(2) != 0);
      clk_enable = ($urandom_range(7) != 0);
      flush      = ($urandom_range(31) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    clk_enable = 1'b1;
    repeat (3) tick();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
